// File: rtl/uart_debug_capture_fifo.sv
// rtl/uart_debug_capture_fifo.sv - address-filtered FWFT capture FIFO feeding the UART debug printer
module uart_debug_capture_fifo #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] ADDR_MASK  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MATCH = 32'h0000_0000,
    parameter int          DROP_W     = 16
) (
    input  logic                       clk,
    input  logic                       anrst,
    input  logic                       cap_valid,
    input  logic                       cap_rnw,
    input  logic [31:0]                cap_addr,
    input  logic [31:0]                cap_data,
    output logic                       empty,
    input  logic                       r_req,
    output logic                       r_rnw,
    output logic [31:0]                r_addr,
    output logic [31:0]                r_data,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 65;

    logic [EW-1:0]     mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    logic              match;
    logic              push_try;
    logic              push;
    logic              pop;
    logic              drop;
    logic [EW-1:0]     head;

    // Filter, push/pop/drop decisions and next-state for pointers, occupancy and drop accounting
    always_comb begin
        match      = ((cap_addr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
        push_try   = cap_valid & match;
        // r_req is ignored while empty, so a push into an empty FIFO is never paired with a pop
        pop        = r_req & ~empty_q;
        // a full FIFO still accepts the push when the same edge pops, freeing the slot
        push       = push_try & (~full_q | pop);
        drop       = push_try & ~push;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));

        // clear takes priority so a drop on the clearing edge is not counted
        if (ovf_clr) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents need no reset because empty gates their use
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cap_rnw, cap_addr, cap_data};
        end
    end

    // First-word-fall-through head read straight from the array
    always_comb begin
        head = mem[rd_ptr_q];
    end

    assign r_rnw    = head[64];
    assign r_addr   = head[63:32];
    assign r_data   = head[31:0];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule
